branch_resolve_unit: RTL and testbench

//  Execute-side counterpart of the fetch-stage branch predictor. Holds an in-order queue
//  of in-flight predictions (pushed at fetch) and pops one when the branch resolves in EX.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/pred_fifo.sv | 70 +++++++
 rtl/branch_resolve_unit.sv | 130 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Definitions shared by the fetch-side predictor and the execute-side resolve unit.
package bp_pkg;

    localparam int XLEN      = 32;
    localparam int BHT_IDX_W = 4;

    typedef struct packed {
        logic                 taken;
        logic [XLEN-1:0]      target;
        logic [XLEN-1:0]      fallthru;
        logic [BHT_IDX_W-1:0] idx;
    } pred_entry_t;

    // 2-bit saturating direction counter states held in the BHT
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

endpackage

// File: rtl/pred_fifo.sv
// Synchronous in-order FIFO of in-flight predictions; clear beats push and pop.
module pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok, pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches resolved branches against queued predictions; emits registered redirect,
// flush and BHT-update pulses and keeps saturating branch/mispredict statistics.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic [XLEN-1:0]  pred_fallthru,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_idx,
    output logic             upd_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic             err
);

    localparam int ENTRY_W = 1 + 2*XLEN + IDX_W;

    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    logic               fifo_full, fifo_empty, pop, mispred;
    logic               e_taken;
    logic [XLEN-1:0]    e_target, e_fallthru;
    logic [IDX_W-1:0]   e_idx;

    logic             upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_taken_q, upd_taken_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic             err_q, err_d;

    // Handshake: a prediction transfers on a rising edge where pred_valid && pred_ready;
    // the producer holds its fields stable until then. res_valid has no back-pressure.
    assign pred_ready = !fifo_full;
    assign wr_entry   = {pred_taken, pred_target, pred_fallthru, pred_idx};
    assign e_taken    = rd_entry[ENTRY_W-1];
    assign e_target   = rd_entry[ENTRY_W-2 -: XLEN];
    assign e_fallthru = rd_entry[IDX_W +: XLEN];
    assign e_idx      = rd_entry[IDX_W-1:0];

    assign pop     = res_valid && !fifo_empty;
    assign mispred = pop && ((res_taken != e_taken) || (res_taken && (res_target != e_target)));

    // A mispredict wipes the queue: everything younger than the oldest entry is wrong-path.
    pred_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (pred_valid),
        .pop     (pop),
        .clear   (mispred),
        .wr_data (wr_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .rd_data (rd_entry)
    );

    always_comb begin
        upd_valid_d      = pop;
        upd_idx_d        = pop ? e_idx : '0;
        upd_taken_d      = pop && res_taken;
        redirect_valid_d = mispred;
        flush_d          = mispred;
        redirect_pc_d    = '0;
        if (mispred) begin
            redirect_pc_d = res_taken ? res_target : e_fallthru;
        end
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (pop && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
        err_d = err_q || (res_valid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_q      <= 1'b0;
            upd_idx_q        <= '0;
            upd_taken_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
            err_q            <= 1'b0;
        end else begin
            upd_valid_q      <= upd_valid_d;
            upd_idx_q        <= upd_idx_d;
            upd_taken_q      <= upd_taken_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
            err_q            <= err_d;
        end
    end

    assign upd_valid      = upd_valid_q;
    assign upd_idx        = upd_idx_q;
    assign upd_taken      = upd_taken_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;
    assign err            = err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand sequences for the
// queue corner cases, then random traffic against a queue-based reference model.
module tb_branch_resolve_unit;

    localparam int DEPTH   = 4;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             pred_valid, pred_taken;
    logic [31:0]      pred_target, pred_fallthru;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_ready;
    logic             res_valid, res_taken;
    logic [31:0]      res_target;
    logic             redirect_valid, flush, upd_valid, upd_taken, err;
    logic [31:0]      redirect_pc;
    logic [IDX_W-1:0] upd_idx;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_fallthru(pred_fallthru), .pred_idx(pred_idx), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .err(err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- types ----------------
    typedef struct {
        logic             pv;
        logic             pt;
        logic [31:0]      ptgt;
        logic [31:0]      pft;
        logic [IDX_W-1:0] pidx;
        logic             rv;
        logic             rt;
        logic [31:0]      rtgt;
    } stim_t;

    typedef struct {
        logic             taken;
        logic [31:0]      target;
        logic [31:0]      fallthru;
        logic [IDX_W-1:0] idx;
    } entry_t;

    typedef struct {
        stim_t            s;
        logic             e_upd;
        logic [IDX_W-1:0] e_idx;
        logic             e_ut;
        logic             e_redir;
        logic [31:0]      e_pc;
    } vec_t;

    // ---------------- reference model state ----------------
    entry_t           mq[$];
    int               m_bcnt, m_mcnt;
    logic             m_err, m_upd, m_ut, m_redir;
    logic [IDX_W-1:0] m_idx;
    logic [31:0]      m_pc;

    logic [IDX_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.pv = 1'b0; s.pt = 1'b0; s.ptgt = '0; s.pft = '0; s.pidx = '0;
        s.rv = 1'b0; s.rt = 1'b0; s.rtgt = '0;
        return s;
    endfunction

    function automatic stim_t mk_push(input logic t, input logic [31:0] tgt,
                                      input logic [31:0] ft, input logic [IDX_W-1:0] idx);
        stim_t s = idle();
        s.pv = 1'b1; s.pt = t; s.ptgt = tgt; s.pft = ft; s.pidx = idx;
        return s;
    endfunction

    function automatic stim_t mk_res(input logic t, input logic [31:0] tgt);
        stim_t s = idle();
        s.rv = 1'b1; s.rt = t; s.rtgt = tgt;
        return s;
    endfunction

    // Advances the model by one clock edge with the given inputs.
    task automatic model_edge(input stim_t s, input logic r);
        bit     full_before, mis;
        entry_t e, n;
        m_upd = 1'b0; m_ut = 1'b0; m_redir = 1'b0; m_idx = '0; m_pc = '0;
        if (r) begin
            mq.delete();
            m_bcnt = 0; m_mcnt = 0; m_err = 1'b0;
            return;
        end
        full_before = (mq.size() >= DEPTH);
        mis = 1'b0;
        if (s.rv) begin
            if (mq.size() == 0) begin
                m_err = 1'b1;
            end else begin
                e = mq.pop_front();
                mis = (s.rt != e.taken) || (s.rt && s.rtgt != e.target);
                m_upd = 1'b1; m_idx = e.idx; m_ut = s.rt;
                if (m_bcnt < CNT_MAX) m_bcnt++;
                if (mis) begin
                    m_redir = 1'b1;
                    m_pc = s.rt ? s.rtgt : e.fallthru;
                    if (m_mcnt < CNT_MAX) m_mcnt++;
                    mq.delete();
                end
            end
        end
        if (s.pv && !full_before && !mis) begin
            n.taken = s.pt; n.target = s.ptgt; n.fallthru = s.pft; n.idx = s.pidx;
            mq.push_back(n);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".upd_valid"}, {31'b0, upd_valid}, {31'b0, m_upd});
        if (m_upd) begin
            chk({tag, ".upd_idx"}, {28'b0, upd_idx}, {28'b0, m_idx});
            chk({tag, ".upd_taken"}, {31'b0, upd_taken}, {31'b0, m_ut});
        end
        chk({tag, ".redirect_valid"}, {31'b0, redirect_valid}, {31'b0, m_redir});
        chk({tag, ".flush"}, {31'b0, flush}, {31'b0, m_redir});
        if (m_redir) chk({tag, ".redirect_pc"}, redirect_pc, m_pc);
        chk({tag, ".branch_cnt"}, {28'b0, branch_cnt}, m_bcnt);
        chk({tag, ".mispred_cnt"}, {28'b0, mispred_cnt}, m_mcnt);
        chk({tag, ".err"}, {31'b0, err}, {31'b0, m_err});
        chk({tag, ".pred_ready"}, {31'b0, pred_ready}, {31'b0, mq.size() < DEPTH});
        chk({tag, ".cnt_order"}, {31'b0, mispred_cnt <= branch_cnt}, 32'd1);
    endtask

    // ---------------- driver ----------------
    task automatic step(input stim_t s, input logic r, input string tag);
        rst = r;
        pred_valid = s.pv; pred_taken = s.pt; pred_target = s.ptgt;
        pred_fallthru = s.pft; pred_idx = s.pidx;
        res_valid = s.rv; res_taken = s.rt; res_target = s.rtgt;
        model_edge(s, r);
        @(posedge clk);
        #1;
        rst = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
        check_outputs(tag);
    endtask

    // ---------------- test ----------------
    vec_t vecs[9];

    initial begin
        stim_t s;
        entry_t f;

        rst = 1'b1; pred_valid = 1'b0; pred_taken = 1'b0; pred_target = '0;
        pred_fallthru = '0; pred_idx = '0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        m_bcnt = 0; m_mcnt = 0; m_err = 1'b0;

        step(idle(), 1'b1, "reset0");
        step(idle(), 1'b1, "reset1");
        chk("reset.pred_ready", {31'b0, pred_ready}, 32'd1);
        chk("reset.branch_cnt", {28'b0, branch_cnt}, 32'd0);

        // directed table: {stimulus, expected pulses after the edge}
        vecs[0] = '{mk_push(1, 32'h100, 32'h24, 4'd3), 0, 4'd0, 0, 0, 32'h0};
        vecs[1] = '{mk_res(1, 32'h100),                1, 4'd3, 1, 0, 32'h0};
        vecs[2] = '{mk_push(0, 32'h80, 32'h44, 4'd5),  0, 4'd0, 0, 0, 32'h0};
        vecs[3] = '{mk_res(1, 32'h80),                 1, 4'd5, 1, 1, 32'h80};
        vecs[4] = '{mk_push(1, 32'h200, 32'h14, 4'd1), 0, 4'd0, 0, 0, 32'h0};
        vecs[5] = '{mk_res(1, 32'h300),                1, 4'd1, 1, 1, 32'h300};
        vecs[6] = '{mk_push(1, 32'h40, 32'h8, 4'd2),   0, 4'd0, 0, 0, 32'h0};
        vecs[7] = '{mk_res(0, 32'h0),                  1, 4'd2, 0, 1, 32'h8};
        vecs[8] = '{idle(),                            0, 4'd0, 0, 0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].s, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("tab%0d.upd_valid", i), {31'b0, upd_valid}, {31'b0, vecs[i].e_upd});
            chk($sformatf("tab%0d.redirect", i), {31'b0, redirect_valid}, {31'b0, vecs[i].e_redir});
            if (vecs[i].e_upd) begin
                chk($sformatf("tab%0d.upd_idx", i), {28'b0, upd_idx}, {28'b0, vecs[i].e_idx});
                chk($sformatf("tab%0d.upd_taken", i), {31'b0, upd_taken}, {31'b0, vecs[i].e_ut});
            end
            if (vecs[i].e_redir)
                chk($sformatf("tab%0d.redirect_pc", i), redirect_pc, vecs[i].e_pc);
        end
        chk("tab.branch_cnt", {28'b0, branch_cnt}, 32'd4);
        chk("tab.mispred_cnt", {28'b0, mispred_cnt}, 32'd3);

        // offset the pointers so the fill below wraps
        step(mk_push(1, 32'h500, 32'h10, 4'd7), 1'b0, "offset_push");
        step(mk_res(1, 32'h500), 1'b0, "offset_res");

        // fill to full, attempt an extra push, drain in order
        for (int i = 0; i < 4; i++) begin
            step(mk_push(1, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 4), IDX_W'(8 + i)), 1'b0, "fill");
            exp_q.push_back(IDX_W'(8 + i));
        end
        chk("full.pred_ready", {31'b0, pred_ready}, 32'd0);
        step(mk_push(1, 32'h9999, 32'h0, 4'd12), 1'b0, "push_when_full");
        chk("full.pred_ready_held", {31'b0, pred_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(mk_res(1, 32'h1000 + 32'(i * 16)), 1'b0, "drain");
            chk("drain.fifo_order", {28'b0, upd_idx}, {28'b0, exp_q.pop_front()});
            chk("drain.no_redirect", {31'b0, redirect_valid}, 32'd0);
        end
        chk("drain.pred_ready", {31'b0, pred_ready}, 32'd1);

        // resolve with nothing queued: extra 5th push must not be there
        step(mk_res(1, 32'h9999), 1'b0, "empty_res");
        chk("empty_res.err", {31'b0, err}, 32'd1);
        chk("empty_res.no_upd", {31'b0, upd_valid}, 32'd0);

        // mispredict on the oldest with a simultaneous push
        for (int i = 0; i < 3; i++)
            step(mk_push(1, 32'h3000 + 32'(i * 8), 32'h4000 + 32'(i * 4), IDX_W'(1 + i)), 1'b0, "q3");
        s = mk_res(0, 32'h0);
        s.pv = 1'b1; s.pt = 1'b1; s.ptgt = 32'h7000; s.pft = 32'h7004; s.pidx = 4'd9;
        step(s, 1'b0, "mis_push");
        chk("mis_push.redirect_pc", redirect_pc, 32'h4000);
        chk("mis_push.flush", {31'b0, flush}, 32'd1);
        step(mk_res(1, 32'h7000), 1'b0, "after_mis");
        chk("after_mis.no_upd", {31'b0, upd_valid}, 32'd0);

        // reset while a pulse is high and entries are queued
        step(mk_push(1, 32'h600, 32'h604, 4'd4), 1'b0, "pre_rst_a");
        step(mk_push(0, 32'h700, 32'h704, 4'd6), 1'b0, "pre_rst_b");
        step(mk_res(1, 32'h600), 1'b0, "pre_rst_res");
        chk("pre_rst.upd_high", {31'b0, upd_valid}, 32'd1);
        s = mk_res(1, 32'h700);
        s.pv = 1'b1; s.pidx = 4'd2;
        step(s, 1'b1, "mid_rst");
        chk("mid_rst.upd_valid", {31'b0, upd_valid}, 32'd0);
        chk("mid_rst.err", {31'b0, err}, 32'd0);
        chk("mid_rst.branch_cnt", {28'b0, branch_cnt}, 32'd0);
        chk("mid_rst.pred_ready", {31'b0, pred_ready}, 32'd1);
        step(mk_push(1, 32'h800, 32'h804, 4'd5), 1'b0, "post_rst_push");
        step(mk_res(1, 32'h800), 1'b0, "post_rst_res");
        chk("post_rst.upd_idx", {28'b0, upd_idx}, 32'd5);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            s = idle();
            s.pv   = 1'($urandom_range(0, 1));
            s.pt   = 1'($urandom_range(0, 1));
            s.ptgt = 32'h100 * 32'($urandom_range(1, 3));
            s.pft  = 32'h10 + 32'(4 * $urandom_range(0, 15));
            s.pidx = IDX_W'($urandom_range(0, 15));
            s.rv   = ($urandom_range(0, 9) < 4);
            if (s.rv && mq.size() != 0 && $urandom_range(0, 3) != 0) begin
                f = mq[0];
                s.rt = f.taken; s.rtgt = f.target;
            end else begin
                s.rt   = 1'($urandom_range(0, 1));
                s.rtgt = 32'h100 * 32'($urandom_range(1, 3));
            end
            step(s, ($urandom_range(0, 149) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
